vend_change_dispenser: RTL and testbench
========================================

// Module: vend_change_dispenser
// PURPOSE
//  Pays out change for the vending controller by driving a coin-hopper motor
//  and counting coins on the hopper's exit sensor.
//  The controller issues a one-cycle request with a coin count. This block
//  feeds coins one at a time, confirms each coin, and reports done or jam.
//  It sits between the vending FSM and the hopper hardware.
// PARAMETERS
//  CNT_W     8     width of the coin-count request and the remaining counter
//  DEB_CYC   4     cycles coin_sense must be stable before an edge is accepted
//  GAP_CYC   16    motor-off cycles between consecutive coins
//  TIMEOUT   1000  max FEED cycles without a detected coin before jam
// PORTS
//  clk          in   1      rising-edge clock
//  rst_n        in   1      asynchronous active-low reset
//  req          in   1      one-cycle pulse: start payout of 'amount' coins
//  amount       in   CNT_W  coins to pay; sampled only when req=1 in IDLE
//  jam_clr      in   1      one-cycle pulse: leave JAM state
//  coin_sense   in   1      raw hopper exit sensor, async, high while coin passes
//  hopper_motor out  1      hopper drive, high = feed
//  busy         out  1      high in every state except IDLE
//  done         out  1      one-cycle pulse when the last coin is confirmed
//  jam          out  1      high while in JAM
//  remaining    out  CNT_W  coins still owed
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; all outputs 0; counters, synchroniser
//   and debounce filter cleared.
//  Input conditioning: coin_sense passes a 2-flop synchroniser, then a filter.
//   The filtered level changes only after DEB_CYC consecutive equal samples.
//   A coin event is a 0->1 transition of the filtered level.
//  States:
//  IDLE:  req=1 with amount!=0 -> remaining<=amount, go to FEED next cycle.
//         req=1 with amount=0  -> done pulses the next cycle; stays IDLE.
//         req is ignored in all other states; there is no queueing.
//  FEED:  hopper_motor=1; the timeout counter increments every cycle.
//         On a coin event: remaining decrements and the timeout counter clears.
//          If remaining was 1, go to DONE; otherwise go to GAP.
//         If the timeout counter reaches TIMEOUT-1 with no coin event, go to JAM.
//  GAP:   hopper_motor=0 for exactly GAP_CYC cycles, then return to FEED.
//         A coin event in GAP is an overpay: remaining saturates at 0 and the
//          block goes to DONE.
//  DONE:  done=1 for exactly one cycle, then IDLE.
//  JAM:   hopper_motor=0, jam=1; remaining holds. Coin events are ignored.
//         jam_clr=1 -> IDLE with remaining cleared to 0; done is not pulsed.
//  Output timing:
//   hopper_motor, busy and jam are registered and decoded from state.
//   remaining updates in the cycle after the coin event is detected.
//  Latency:
//   req to hopper_motor=1 is 1 cycle.
//   A sensor edge takes 2 (sync) + DEB_CYC cycles to become a coin event.
//  Simultaneous events:
//   A coin event and the timeout in the same cycle: the coin wins.
//   jam_clr outside JAM has no effect.
//  Reset mid-payout aborts immediately: motor off, remaining=0, done not pulsed.
//  remaining never underflows; decrement below 0 is blocked.
// TESTING
//  1. req, amount=3; sensor pulses 8 cycles wide, one per FEED ->
//     remaining 3->2->1->0; two GAP windows of 16 cycles; one done pulse.
//  2. req, amount=0 -> done high exactly one cycle later; motor never rises;
//     busy stays 0.
//  3. req, amount=2; no sensor activity -> jam=1 after 1000 FEED cycles,
//     motor=0, remaining=2; then jam_clr -> IDLE, remaining=0, no done.
//  4. Sensor glitches 1-3 cycles wide during FEED -> no decrement;
//     a clean 6-cycle pulse -> exactly one decrement.
//  5. rst_n low mid-FEED with remaining=5 -> all outputs 0 immediately;
//     a later req, amount=1 completes normally.
//  6. Second req during payout is ignored; a coin event in GAP with
//     remaining=1 -> DONE, remaining=0.

Source files
------------

// File: rtl/vend_change_dispenser_if.sv
// Handshake and hopper signals between the vending controller and the change dispenser.
// The master side is the controller plus the hopper sensor; the slave side is the dispenser.
interface vend_change_dispenser_if #(
  parameter int unsigned CNT_W = 8
);
  logic             req;
  logic [CNT_W-1:0] amount;
  logic             jam_clr;
  logic             coin_sense;
  logic             hopper_motor;
  logic             busy;
  logic             done;
  logic             jam;
  logic [CNT_W-1:0] remaining;

  modport master (
    output req, amount, jam_clr, coin_sense,
    input  hopper_motor, busy, done, jam, remaining
  );

  modport slave (
    input  req, amount, jam_clr, coin_sense,
    output hopper_motor, busy, done, jam, remaining
  );
endinterface

// File: rtl/vend_change_dispenser.sv
// Coin-hopper change dispenser: feeds coins one at a time, confirms each on the
// debounced exit sensor, and reports done or jam back to the vending controller.
module vend_change_dispenser #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DEB_CYC = 4,
  parameter int unsigned GAP_CYC = 16,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  vend_change_dispenser_if.slave bus
);

  localparam int unsigned DEB_W = $clog2(DEB_CYC + 1);
  localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FEED,
    ST_GAP,
    ST_DONE,
    ST_JAM
  } state_t;

  state_t           state, state_n;
  logic [1:0]       sync_q;
  logic             filt_q;
  logic [DEB_W-1:0] deb_q;
  logic [TMO_W-1:0] tmo_q, tmo_n;
  logic [GAP_W-1:0] gap_q, gap_n;
  logic [CNT_W-1:0] rem_q, rem_n;
  logic             motor_q, busy_q, done_q, jam_q, done_n;
  logic             coin_evt_c;

  // Rising edge of the filtered level, seen in the cycle before the filter flips.
  assign coin_evt_c = sync_q[1] && !filt_q && (deb_q == DEB_W'(DEB_CYC - 1));

  // Two-flop synchroniser followed by a stable-count debounce filter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      filt_q <= 1'b0;
      deb_q  <= '0;
    end else begin
      sync_q <= {sync_q[0], bus.coin_sense};
      if (sync_q[1] == filt_q) begin
        deb_q <= '0;
      end else if (deb_q == DEB_W'(DEB_CYC - 1)) begin
        filt_q <= sync_q[1];
        deb_q  <= '0;
      end else begin
        deb_q <= deb_q + DEB_W'(1);
      end
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      tmo_q   <= '0;
      gap_q   <= '0;
      rem_q   <= '0;
      motor_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      jam_q   <= 1'b0;
    end else begin
      state   <= state_n;
      tmo_q   <= tmo_n;
      gap_q   <= gap_n;
      rem_q   <= rem_n;
      motor_q <= (state_n == ST_FEED);
      busy_q  <= (state_n != ST_IDLE);
      done_q  <= done_n;
      jam_q   <= (state_n == ST_JAM);
    end
  end

  always_comb begin
    state_n = state;
    rem_n   = rem_q;
    tmo_n   = '0;
    gap_n   = '0;
    done_n  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.req) begin
          if (bus.amount != '0) begin
            rem_n   = bus.amount;
            state_n = ST_FEED;
          end else begin
            done_n = 1'b1;
          end
        end
      end
      ST_FEED: begin
        // A coin arriving on the timeout cycle still counts.
        if (coin_evt_c) begin
          rem_n   = (rem_q != '0) ? rem_q - CNT_W'(1) : '0;
          state_n = (rem_q <= CNT_W'(1)) ? ST_DONE : ST_GAP;
        end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
          state_n = ST_JAM;
        end else begin
          tmo_n = tmo_q + TMO_W'(1);
        end
      end
      ST_GAP: begin
        // A coin dropping while the motor is off is an overpay; close the payout.
        if (coin_evt_c) begin
          rem_n   = '0;
          state_n = ST_DONE;
        end else if (gap_q == GAP_W'(GAP_CYC - 1)) begin
          state_n = ST_FEED;
        end else begin
          gap_n = gap_q + GAP_W'(1);
        end
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      ST_JAM: begin
        if (bus.jam_clr) begin
          rem_n   = '0;
          state_n = ST_IDLE;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    if (state_n == ST_DONE) done_n = 1'b1;
  end

  assign bus.hopper_motor = motor_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.jam          = jam_q;
  assign bus.remaining    = rem_q;

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Directed bench for the change dispenser: payout, zero request, jam/clear,
// glitch rejection, reset abort and overpay during the gap.
module tb_vend_change_dispenser;

  logic clk;
  logic rst_n;
  int   vecs;
  int   errs;
  int   done_total;
  int   gap_total;

  vend_change_dispenser_if #(.CNT_W(8)) dif ();

  vend_change_dispenser #(
    .CNT_W(8), .DEB_CYC(4), .GAP_CYC(16), .TIMEOUT(1000)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (dif)
  );

  always #5 clk = ~clk;

  // Count done pulses and motor-off gap cycles during a payout.
  always @(negedge clk) begin
    if (rst_n) begin
      if (dif.done) done_total = done_total + 1;
      if (dif.busy && !dif.hopper_motor && !dif.done && !dif.jam) gap_total = gap_total + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int n);
    dif.coin_sense = 1'b1;
    repeat (n) tick();
    dif.coin_sense = 1'b0;
  endtask

  task automatic request(input logic [7:0] amt);
    dif.req    = 1'b1;
    dif.amount = amt;
    tick();
    dif.req    = 1'b0;
    dif.amount = 8'd0;
  endtask

  task automatic wait_motor(output int cyc);
    cyc = 0;
    while (!dif.hopper_motor && cyc < 100) begin
      tick();
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    vecs++; if ({dif.hopper_motor, dif.busy, dif.done, dif.jam} !== 4'b0000) begin errs++; $display("FAIL reset_flags: got %b want 0000", {dif.hopper_motor, dif.busy, dif.done, dif.jam}); end
    vecs++; if (dif.remaining !== 8'd0) begin errs++; $display("FAIL reset_remaining: got %0d want 0", dif.remaining); end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_payout3();
    int d0, g0, c;
    d0 = done_total; g0 = gap_total;
    request(8'd3);
    vecs++; if ({dif.hopper_motor, dif.busy} !== 2'b11) begin errs++; $display("FAIL p3_start_motor_busy: got %b want 11", {dif.hopper_motor, dif.busy}); end
    vecs++; if (dif.remaining !== 8'd3) begin errs++; $display("FAIL p3_start_remaining: got %0d want 3", dif.remaining); end
    for (int i = 0; i < 3; i++) begin
      pulse(8);
      vecs++; if (dif.remaining !== 8'(2 - i)) begin errs++; $display("FAIL p3_remaining_coin%0d: got %0d want %0d", i, dif.remaining, 2 - i); end
      if (i < 2) begin
        wait_motor(c);
        vecs++; if (dif.hopper_motor !== 1'b1) begin errs++; $display("FAIL p3_motor_back%0d: got %b want 1 (timeout)", i, dif.hopper_motor); end
      end
    end
    tick();
    vecs++; if (dif.busy !== 1'b0) begin errs++; $display("FAIL p3_idle_busy: got %b want 0", dif.busy); end
    vecs++; if (done_total - d0 !== 1) begin errs++; $display("FAIL p3_done_count: got %0d want 1", done_total - d0); end
    vecs++; if (gap_total - g0 !== 32) begin errs++; $display("FAIL p3_gap_cycles: got %0d want 32", gap_total - g0); end
  endtask

  task automatic test_zero_amount();
    request(8'd0);
    vecs++; if (dif.done !== 1'b1) begin errs++; $display("FAIL zero_done: got %b want 1", dif.done); end
    vecs++; if ({dif.hopper_motor, dif.busy} !== 2'b00) begin errs++; $display("FAIL zero_motor_busy: got %b want 00", {dif.hopper_motor, dif.busy}); end
    tick();
    vecs++; if ({dif.done, dif.hopper_motor, dif.busy} !== 3'b000) begin errs++; $display("FAIL zero_after: got %b want 000", {dif.done, dif.hopper_motor, dif.busy}); end
  endtask

  task automatic test_jam();
    int d0, c;
    d0 = done_total;
    request(8'd2);
    c = 0;
    while (!dif.jam && c < 1100) begin
      tick();
      c++;
    end
    vecs++; if (c !== 1000) begin errs++; $display("FAIL jam_latency: got %0d want 1000", c); end
    vecs++; if ({dif.jam, dif.hopper_motor, dif.busy} !== 3'b101) begin errs++; $display("FAIL jam_flags: got %b want 101", {dif.jam, dif.hopper_motor, dif.busy}); end
    vecs++; if (dif.remaining !== 8'd2) begin errs++; $display("FAIL jam_remaining: got %0d want 2", dif.remaining); end
    pulse(8);
    repeat (4) tick();
    vecs++; if ({dif.jam, dif.remaining} !== {1'b1, 8'd2}) begin errs++; $display("FAIL jam_coin_ignored: got jam=%b rem=%0d want jam=1 rem=2", dif.jam, dif.remaining); end
    dif.jam_clr = 1'b1;
    tick();
    dif.jam_clr = 1'b0;
    vecs++; if ({dif.jam, dif.busy} !== 2'b00) begin errs++; $display("FAIL jam_clr_flags: got %b want 00", {dif.jam, dif.busy}); end
    vecs++; if (dif.remaining !== 8'd0) begin errs++; $display("FAIL jam_clr_remaining: got %0d want 0", dif.remaining); end
    tick();
    vecs++; if (done_total - d0 !== 0) begin errs++; $display("FAIL jam_no_done: got %0d want 0", done_total - d0); end
  endtask

  task automatic test_glitch();
    int c;
    request(8'd2);
    for (int w = 1; w <= 3; w++) begin
      pulse(w);
      repeat (8) tick();
    end
    vecs++; if (dif.remaining !== 8'd2) begin errs++; $display("FAIL glitch_reject: got %0d want 2", dif.remaining); end
    pulse(6);
    vecs++; if (dif.remaining !== 8'd1) begin errs++; $display("FAIL glitch_clean_pulse: got %0d want 1", dif.remaining); end
    wait_motor(c);
    pulse(8);
    tick();
    vecs++; if ({dif.remaining, dif.busy} !== {8'd0, 1'b0}) begin errs++; $display("FAIL glitch_finish: got rem=%0d busy=%b want rem=0 busy=0", dif.remaining, dif.busy); end
  endtask

  task automatic test_reset_abort();
    int d0;
    request(8'd5);
    repeat (5) tick();
    vecs++; if (dif.remaining !== 8'd5) begin errs++; $display("FAIL abort_pre_remaining: got %0d want 5", dif.remaining); end
    d0 = done_total;
    rst_n = 1'b0;
    #1;
    vecs++; if ({dif.hopper_motor, dif.busy, dif.done, dif.jam, dif.remaining} !== 12'd0) begin errs++; $display("FAIL abort_outputs: got motor=%b busy=%b rem=%0d want all 0", dif.hopper_motor, dif.busy, dif.remaining); end
    #2;
    rst_n = 1'b1;
    repeat (2) tick();
    request(8'd1);
    pulse(8);
    tick();
    vecs++; if ({dif.remaining, dif.busy} !== {8'd0, 1'b0}) begin errs++; $display("FAIL abort_next_payout: got rem=%0d busy=%b want rem=0 busy=0", dif.remaining, dif.busy); end
    vecs++; if (done_total - d0 !== 1) begin errs++; $display("FAIL abort_done_count: got %0d want 1", done_total - d0); end
  endtask

  task automatic test_back_to_back();
    int d0;
    d0 = done_total;
    request(8'd2);
    tick();
    request(8'd7);
    vecs++; if (dif.remaining !== 8'd2) begin errs++; $display("FAIL b2b_req_ignored: got %0d want 2", dif.remaining); end
    pulse(6);
    vecs++; if ({dif.remaining, dif.hopper_motor} !== {8'd1, 1'b0}) begin errs++; $display("FAIL b2b_in_gap: got rem=%0d motor=%b want rem=1 motor=0", dif.remaining, dif.hopper_motor); end
    repeat (5) tick();
    pulse(6);
    vecs++; if (dif.remaining !== 8'd0) begin errs++; $display("FAIL b2b_overpay_remaining: got %0d want 0", dif.remaining); end
    tick();
    vecs++; if (done_total - d0 !== 1) begin errs++; $display("FAIL b2b_overpay_done: got %0d want 1", done_total - d0); end
    vecs++; if ({dif.busy, dif.hopper_motor} !== 2'b00) begin errs++; $display("FAIL b2b_idle: got %b want 00", {dif.busy, dif.hopper_motor}); end
  endtask

  initial begin
    clk            = 1'b0;
    rst_n          = 1'b0;
    vecs           = 0;
    errs           = 0;
    done_total     = 0;
    gap_total      = 0;
    dif.req        = 1'b0;
    dif.amount     = 8'd0;
    dif.jam_clr    = 1'b0;
    dif.coin_sense = 1'b0;
    test_reset();
    test_payout3();
    test_zero_amount();
    test_jam();
    test_glitch();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
